// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    // Controller state: normal flow, or holding ID while the multiply/divide unit works.
    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StMduWait = 1'b1
    } hz_state_e;

    // Architectural zero register; never a real load destination.
    localparam logic [4:0] RegZero = 5'd0;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return memread && (ex_rt != RegZero) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_discard_instr.sv
// IF/ID flush decode for control redirects resolved in ID.
// A jump only discards the fetched instruction; a taken branch or register jump also
// turns the instruction behind it in ID/EX into a bubble.
module discard_instr (
    input  logic jump,
    input  logic bne,
    input  logic jr,
    output logic if_flush,
    output logic id_flush
);

    // Pure decode of the redirect type into the two flush requests.
    always_comb begin
        if_flush = jump | bne | jr;
        id_flush = bne | jr;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multiply/divide busy stalls,
// control-redirect flushes and a saturating count of IF flush cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump,
    input  logic             bne,
    input  logic             jr,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             mdu_start,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             IF_flush,
    output logic             ID_flush,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] flush_count
);

    // MDU_LAT >= 2 keeps this at least one bit wide.
    localparam int unsigned CntW = $clog2(MDU_LAT);
    localparam logic [CntW-1:0] CntLoad = CntW'(MDU_LAT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CNT_W-1:0] FcntOne = CNT_W'(1);

    hz_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    logic load_use;
    logic in_wait;
    logic stall;
    logic dec_if_flush;
    logic dec_id_flush;

    // Hazard detection, evaluated in the same cycle as the ID instruction.
    always_comb begin
        load_use = load_use_hit(id_ex_memread, id_ex_rt, if_id_rs, if_id_rt);
        in_wait  = (state_q == StMduWait);
        stall    = in_wait | load_use;
    end

    discard_instr u_discard_instr (
        .jump     (jump),
        .bne      (bne),
        .jr       (jr),
        .if_flush (dec_if_flush),
        .id_flush (dec_id_flush)
    );

    // Pipeline control outputs; reset overrides everything, then stalls override redirects.
    // A redirect hidden by a stall is not lost: ID holds the instruction and it re-decodes.
    always_comb begin
        pc_we    = 1'b1;
        if_id_we = 1'b1;
        IF_flush = 1'b0;
        ID_flush = 1'b0;
        mdu_busy = 1'b0;
        mdu_done = 1'b0;
        if (rst) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            IF_flush = 1'b1;
            ID_flush = 1'b1;
        end else if (stall) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            IF_flush = 1'b0;
            ID_flush = 1'b1;
            mdu_busy = in_wait;
            mdu_done = in_wait && (cnt_q == '0);
        end else begin
            IF_flush = dec_if_flush;
            ID_flush = dec_id_flush;
        end
    end

    // Next-state logic; the issuing cycle runs normally and MDU_LAT wait cycles follow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                // A start blocked by load-use is dropped; ID re-presents it next cycle.
                if (mdu_start && !load_use) begin
                    state_d = StMduWait;
                    cnt_d   = CntLoad;
                end
            end
            StMduWait: begin
                if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating count of cycles that discarded the fetched instruction.
    always_comb begin
        fcnt_d = fcnt_q;
        if (IF_flush && (fcnt_q != '1)) begin
            fcnt_d = fcnt_q + FcntOne;
        end
    end

    // State registers with synchronous reset; an in-flight MDU sequence is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign flush_count = fcnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl. Two instances share stimulus:
// [0] MDU_LAT=4, CNT_W=4 (saturates quickly), [1] MDU_LAT=2, CNT_W=16 (minimum latency).
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, jump, bne, jr, id_ex_memread, mdu_start;
    logic [4:0] id_ex_rt, if_id_rs, if_id_rt;

    logic        pc_we_w[2], if_id_we_w[2], if_fl_w[2], id_fl_w[2], busy_w[2], done_w[2];
    logic [3:0]  fc_a;
    logic [15:0] fc_b;

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .jump          (jump),
        .bne           (bne),
        .jr            (jr),
        .id_ex_memread (id_ex_memread),
        .id_ex_rt      (id_ex_rt),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .mdu_start     (mdu_start),
        .pc_we         (pc_we_w[0]),
        .if_id_we      (if_id_we_w[0]),
        .IF_flush      (if_fl_w[0]),
        .ID_flush      (id_fl_w[0]),
        .mdu_busy      (busy_w[0]),
        .mdu_done      (done_w[0]),
        .flush_count   (fc_a)
    );

    pipe_hazard_ctrl #(.MDU_LAT(2), .CNT_W(16)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .jump          (jump),
        .bne           (bne),
        .jr            (jr),
        .id_ex_memread (id_ex_memread),
        .id_ex_rt      (id_ex_rt),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .mdu_start     (mdu_start),
        .pc_we         (pc_we_w[1]),
        .if_id_we      (if_id_we_w[1]),
        .IF_flush      (if_fl_w[1]),
        .ID_flush      (id_fl_w[1]),
        .mdu_busy      (busy_w[1]),
        .mdu_done      (done_w[1]),
        .flush_count   (fc_b)
    );

    // Reference model: remaining MDU stall cycles and flush count per instance.
    int lat[2]  = '{4, 2};
    int fmax[2] = '{15, 65535};
    int left[2] = '{0, 0};
    int fc[2]   = '{0, 0};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit model_lu();
        return id_ex_memread && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    endfunction

    task automatic check_cycle(input string tag);
        for (int k = 0; k < 2; k++) begin
            bit stall;
            int e_pc, e_ifid, e_if, e_id, e_busy, e_done, o_fc;
            stall = (left[k] > 0) || model_lu();
            if (rst) begin
                e_pc = 0; e_ifid = 0; e_if = 1; e_id = 1; e_busy = 0; e_done = 0;
            end else if (stall) begin
                e_pc = 0; e_ifid = 0; e_if = 0; e_id = 1;
                e_busy = (left[k] > 0) ? 1 : 0;
                e_done = (left[k] == 1) ? 1 : 0;
            end else begin
                e_pc = 1; e_ifid = 1; e_busy = 0; e_done = 0;
                e_if = (jump || bne || jr) ? 1 : 0;
                e_id = (bne || jr) ? 1 : 0;
            end
            o_fc = (k == 0) ? int'(fc_a) : int'(fc_b);
            check($sformatf("%s/%0d/pc_we", tag, k), pc_we_w[k], e_pc);
            check($sformatf("%s/%0d/if_id_we", tag, k), if_id_we_w[k], e_ifid);
            check($sformatf("%s/%0d/IF_flush", tag, k), if_fl_w[k], e_if);
            check($sformatf("%s/%0d/ID_flush", tag, k), id_fl_w[k], e_id);
            check($sformatf("%s/%0d/mdu_busy", tag, k), busy_w[k], e_busy);
            check($sformatf("%s/%0d/mdu_done", tag, k), done_w[k], e_done);
            check($sformatf("%s/%0d/flush_count", tag, k), o_fc, fc[k]);
        end
    endtask

    task automatic update_model();
        for (int k = 0; k < 2; k++) begin
            bit lu, flushed;
            lu = model_lu();
            if (rst) begin
                left[k] = 0;
                fc[k]   = 0;
            end else begin
                flushed = !((left[k] > 0) || lu) && (jump || bne || jr);
                if (left[k] > 0) left[k]--;
                else if (mdu_start && !lu) left[k] = lat[k];
                if (flushed && fc[k] < fmax[k]) fc[k]++;
            end
        end
    endtask

    task automatic drive(input bit r, input bit j, input bit b, input bit rj, input bit mr,
                         input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                         input bit ms);
        rst = r; jump = j; bne = b; jr = rj; id_ex_memread = mr;
        id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt; mdu_start = ms;
    endtask

    // Check mid-cycle, advance the model, then step past the active edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_cycle(tag);
        update_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        @(posedge clk);
        #1;
        cycle("reset");
        cycle("reset");

        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("idle");

        drive(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0);
        cycle("load_use");
        drive(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd3, 0);
        cycle("load_use_release");

        drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        cycle("zero_reg");

        drive(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1);
        cycle("mdu_issue");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
        for (int i = 0; i < 6; i++) cycle("mdu_wait");

        drive(0, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0);
        cycle("bne");
        drive(0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
        cycle("jump");
        drive(0, 0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0);
        cycle("jr");

        drive(0, 0, 1, 0, 1, 5'd5, 5'd1, 5'd5, 0);
        cycle("bne_load_use");

        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
        cycle("mdu_rst_issue");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("mdu_rst_c1");
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("mdu_rst_c2");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 4; i++) cycle("mdu_rst_after");

        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("sat_reset");
        drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 20; i++) cycle("sat_jump");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        check("sat_a_value", fc_a, 15);
        check("sat_b_value", fc_b, 20);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
